exponent_alu: RTL and testbench
===============================

EXPONENT_ALU -- requirements
Module: exponent_alu

Interface
- REQ-001: Parameter EXP_W, default 8: exponent field width in bits; legal range 4..15.
- REQ-002: Parameter BIAS, default 127: exponent bias; legal range 0..2^EXP_W-1.
- REQ-003: clk  input  1  single clock; all state updates on its rising edge.
- REQ-004: rst_n  input  1  reset; asynchronous assertion, active-low.
- REQ-005: in_valid  input  1  operand set offered.
- REQ-006: in_ready  output  1  block accepts operands this cycle.
- REQ-007: a  input  EXP_W  biased exponent A, unsigned.
- REQ-008: b  input  EXP_W  biased exponent B, unsigned.
- REQ-009: op  input  2  operation: 00 MUL, 01 DIV, 10 ALIGN, 11 ZERO.
- REQ-010: out_valid  output  1  result held for downstream.
- REQ-011: out_ready  input  1  downstream accepts result this cycle.
- REQ-012: res  output  EXP_W+2  two's-complement result.
- REQ-013: ovf  output  1  MUL/DIV result at or above 2^EXP_W-1.
- REQ-014: unf  output  1  MUL/DIV result at or below 0.
- REQ-015: swap  output  1  ALIGN only: B > A.

Function
- REQ-016: MUL computes A+B-BIAS, DIV computes A-B+BIAS, ALIGN computes |A-B|, ZERO yields 0; all internal arithmetic is EXP_W+2 bits signed with no truncation.
- REQ-017: ALIGN and ZERO force ovf=0 and unf=0; swap=0 for every op except ALIGN.
- REQ-018: Transfer in occurs when in_valid and in_ready are both 1; transfer out occurs when out_valid and out_ready are both 1.
- REQ-019: Two register stages: S1 captures operands, op and raw sum; S2 holds res, flags and swap.
- REQ-020: Latency is exactly 2 cycles from transfer-in to out_valid when out_ready stays 1; throughput is one op per cycle.
- REQ-021: A stage loads when it is empty or when its contents move on in the same cycle; in_ready = !S1_valid | S2 loading.
- REQ-022: With out_ready=0, S2 holds res, ovf, unf and swap unchanged; a second op waits in S1; in_ready drops to 0 once both stages are full.
- REQ-023: A simultaneous transfer-out and transfer-in in the same cycle loses no data and preserves order.
- REQ-024: in_valid with in_ready=0 has no effect; a, b and op are ignored whenever no transfer-in occurs.

Reset
- REQ-025: When rst_n is 0: S1_valid=0, S2_valid=0, out_valid=0, res=0, ovf=0, unf=0, swap=0; in_ready=1 from the first cycle after rst_n returns to 1.
- REQ-026: Reset mid-operation discards every in-flight op; no stale result is presented after reset is released.

Configuration
- REQ-027: With macro EXPONENT_ALU_SATURATE_EN defined, MUL/DIV results are clamped: ovf forces res=2^EXP_W-1 and unf forces res=0; flags still assert.
- REQ-028: With EXPONENT_ALU_SATURATE_EN undefined, res carries the unclamped signed value and only the flags report the range violation.

Structure
- REQ-029: Package fpu_pkg holds the op encoding constants (OP_MUL, OP_DIV, OP_ALIGN, OP_ZERO) and the defaults EXP_W_DEF=8 and BIAS_DEF=127.
- REQ-030: One sub-module, exp_pipe_stage, is a parametrised valid/ready register slice instantiated twice.

Verification (EXP_W=8, BIAS=127)
- REQ-031: Case MUL. Stimulus: a=130, b=129, out_ready=1. Required: res=132, ovf=0, unf=0, out_valid exactly 2 cycles after transfer-in.
- REQ-032: Case DIV. Stimulus: a=100, b=200. Required: res=27, no flags.
- REQ-033: Case MUL overflow and underflow.
  - a=200, b=200: ovf=1; res=273 without the macro, 255 with it.
  - a=10, b=20: unf=1; res=-97 without the macro, 0 with it.
- REQ-034: Case ALIGN. Stimulus: a=5, b=9. Required: res=4, swap=1. Stimulus: a=9, b=5. Required: res=4, swap=0.
- REQ-035: Case backpressure. Stimulus: 3 back-to-back ops with out_ready=0 for 5 cycles. Required: in_ready=0 after 2 ops are accepted; the 3 results appear in order with no loss once out_ready=1.
- REQ-036: Case reset mid-operation. Stimulus: rst_n pulsed low with both stages full. Required: out_valid=0 immediately and in_ready=1 after release.

Source files
------------

// File: rtl/fpu_pkg.sv
// Shared definitions for the exponent datapath: operation encoding,
// default field geometry and a small op-classification helper.
package fpu_pkg;

    // Default exponent geometry (IEEE-754 single precision).
    localparam int EXP_W_DEF = 8;
    localparam int BIAS_DEF  = 127;

    // Operation encoding carried on the op input.
    typedef enum logic [1:0] {
        OP_MUL   = 2'b00,
        OP_DIV   = 2'b01,
        OP_ALIGN = 2'b10,
        OP_ZERO  = 2'b11
    } op_e;

    // MUL and DIV are the only ops whose result is range-checked.
    function automatic logic is_arith(input logic [1:0] op);
        return (op == OP_MUL) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/exp_pipe_stage.sv
// Generic valid/ready register slice. Holds one data word; accepts a new
// word when empty or when the held word leaves in the same cycle, so a
// chain of these sustains one transfer per cycle without bubbles.
module exp_pipe_stage #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic load;

    assign in_ready = !out_valid || out_ready;
    assign load     = in_valid && in_ready;

    // Capture on load, empty out once the held word is taken, otherwise hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_data  <= in_data;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/exponent_alu.sv
// Two-stage pipelined exponent ALU for a floating-point unit.
// S1 holds operands, op and the raw signed result; S2 holds the final
// result, range flags and the ALIGN swap indication.
// Optional feature: define EXPONENT_ALU_SATURATE_EN to clamp MUL/DIV
// results into [0, 2^EXP_W-1]; otherwise res carries the raw signed value.
module exponent_alu
    import fpu_pkg::*;
#(
    parameter int EXP_W = EXP_W_DEF,
    parameter int BIAS  = BIAS_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [EXP_W-1:0] a,
    input  logic [EXP_W-1:0] b,
    input  logic [1:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [EXP_W+1:0] res,
    output logic             ovf,
    output logic             unf,
    output logic             swap
);

    // Internal arithmetic width: two guard bits cover sign plus the carry
    // of A+B, so no intermediate is ever truncated.
    localparam int W   = EXP_W + 2;
    localparam int S1W = 2 + 2 * EXP_W + W;
    localparam int S2W = W + 3;

    localparam logic signed [W-1:0] BIAS_X = W'(BIAS);
    localparam logic signed [W-1:0] MAX_X  = W'((1 << EXP_W) - 1);
    localparam logic signed [W-1:0] ZERO_X = '0;

    logic signed [W-1:0] a_x;
    logic signed [W-1:0] b_x;
    logic signed [W-1:0] raw;

    logic [S1W-1:0]      s1_in;
    logic [S1W-1:0]      s1_out;
    logic                s1_valid;
    logic                s2_in_ready;

    logic [1:0]          s1_op;
    logic [EXP_W-1:0]    s1_a;
    logic [EXP_W-1:0]    s1_b;
    logic signed [W-1:0] s1_raw;

    logic signed [W-1:0] res_n;
    logic                ovf_n;
    logic                unf_n;
    logic                swap_n;

    logic [S2W-1:0]      s2_in;
    logic [S2W-1:0]      s2_out;

    assign a_x = {2'b00, a};
    assign b_x = {2'b00, b};

    // Stage 0: form the raw signed result for the requested operation.
    always_comb begin
        raw = '0;
        case (op)
            OP_MUL:   raw = a_x + b_x - BIAS_X;
            OP_DIV:   raw = a_x - b_x + BIAS_X;
            OP_ALIGN: raw = (a >= b) ? (a_x - b_x) : (b_x - a_x);
            OP_ZERO:  raw = '0;
            default:  raw = '0;
        endcase
    end

    assign s1_in = {op, a, b, raw};

    exp_pipe_stage #(.W(S1W)) u_s1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (s1_in),
        .out_valid (s1_valid),
        .out_ready (s2_in_ready),
        .out_data  (s1_out)
    );

    assign {s1_op, s1_a, s1_b, s1_raw} = s1_out;

    // Stage 1: range-check MUL/DIV, flag ALIGN swap, optionally clamp.
    always_comb begin
        ovf_n  = is_arith(s1_op) && (s1_raw >= MAX_X);
        unf_n  = is_arith(s1_op) && (s1_raw <= ZERO_X);
        swap_n = (s1_op == OP_ALIGN) && (s1_b > s1_a);
        res_n  = s1_raw;
`ifdef EXPONENT_ALU_SATURATE_EN
        if (ovf_n) begin
            res_n = MAX_X;
        end else if (unf_n) begin
            res_n = ZERO_X;
        end
`endif
    end

    assign s2_in = {res_n, ovf_n, unf_n, swap_n};

    exp_pipe_stage #(.W(S2W)) u_s2 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (s1_valid),
        .in_ready  (s2_in_ready),
        .in_data   (s2_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (s2_out)
    );

    assign {res, ovf, unf, swap} = s2_out;

endmodule

// File: tb/tb_exponent_alu.sv
// Self-checking bench for exponent_alu (EXP_W=8, BIAS=127).
// Expected results come from an integer reference model and a FIFO of
// accepted operations; pipeline capacity is modelled as "at most two
// operations in flight".
module tb_exponent_alu;

    localparam int EXP_W = 8;
    localparam int BIAS  = 127;
    localparam int MAXV  = (1 << EXP_W) - 1;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [EXP_W-1:0] a;
    logic [EXP_W-1:0] b;
    logic [1:0]       op;
    logic             out_valid;
    logic             out_ready;
    logic [EXP_W+1:0] res;
    logic             ovf;
    logic             unf;
    logic             swap;

    typedef struct {
        int res;
        bit ovf;
        bit unf;
        bit swap;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   out_count = 0;
    int   last_res = 0;
    bit   last_ovf, last_unf, last_swap;
    bit   accepted;

    exponent_alu #(.EXP_W(EXP_W), .BIAS(BIAS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .res       (res),
        .ovf       (ovf),
        .unf       (unf),
        .swap      (swap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model straight from the operation definitions.
    function automatic exp_t model(input int opc, input int av, input int bv);
        exp_t e;
        e = '{0, 1'b0, 1'b0, 1'b0};
        case (opc)
            0: e.res = av + bv - BIAS;
            1: e.res = av - bv + BIAS;
            2: e.res = (av > bv) ? av - bv : bv - av;
            default: e.res = 0;
        endcase
        if (opc < 2) begin
            e.ovf = (e.res >= MAXV);
            e.unf = (e.res <= 0);
        end
        e.swap = (opc == 2) && (bv > av);
`ifdef EXPONENT_ALU_SATURATE_EN
        if (e.ovf) e.res = MAXV;
        if (e.unf) e.res = 0;
`endif
        return e;
    endfunction

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // One clock cycle: drive inputs, check handshake and any transfer-out,
    // record any transfer-in in the expectation FIFO.
    task automatic applyStimulus(input bit v, input int opc, input int av, input int bv, input bit ordy);
        exp_t e;
        @(negedge clk);
        in_valid  = v;
        op        = opc[1:0];
        a         = av[EXP_W-1:0];
        b         = bv[EXP_W-1:0];
        out_ready = ordy;
        #1;
        checkOutput("in_ready", int'(in_ready), int'(!(q.size() == 2 && !ordy)));
        accepted = in_valid && in_ready;
        if (out_valid && out_ready) begin
            if (q.size() == 0) begin
                checkOutput("spurious_out_valid", int'(out_valid), 0);
            end else begin
                e = q.pop_front();
                out_count++;
                last_res  = int'($signed(res));
                last_ovf  = ovf;
                last_unf  = unf;
                last_swap = swap;
                checkOutput("res", last_res, e.res);
                checkOutput("ovf", int'(ovf), int'(e.ovf));
                checkOutput("unf", int'(unf), int'(e.unf));
                checkOutput("swap", int'(swap), int'(e.swap));
            end
        end
        if (accepted) q.push_back(model(opc, av, bv));
    endtask

    task automatic drain(input int max_cycles);
        int n = 0;
        while (q.size() > 0 && n < max_cycles) begin
            applyStimulus(1'b0, 0, 0, 0, 1'b1);
            n++;
        end
        if (q.size() != 0) checkOutput("drain_timeout", q.size(), 0);
    endtask

    initial begin
        rst_n     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        op        = '0;
        #2 rst_n = 1'b0;
        #1;
        checkOutput("reset_out_valid", int'(out_valid), 0);
        checkOutput("reset_res", int'(res), 0);
        checkOutput("reset_ovf", int'(ovf), 0);
        checkOutput("reset_unf", int'(unf), 0);
        checkOutput("reset_swap", int'(swap), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // MUL with exact latency check.
        applyStimulus(1'b1, 0, 130, 129, 1'b1);
        checkOutput("mul_accepted", int'(accepted), 1);
        applyStimulus(1'b0, 0, 0, 0, 1'b1);
        checkOutput("mul_lat_cycle1", int'(out_valid), 0);
        applyStimulus(1'b0, 0, 0, 0, 1'b1);
        checkOutput("mul_lat_cycle2", int'(out_valid), 1);
        drain(5);
        checkOutput("mul_res_const", last_res, 132);

        // DIV.
        applyStimulus(1'b1, 1, 100, 200, 1'b1);
        drain(6);
        checkOutput("div_res_const", last_res, 27);
        checkOutput("div_flags", int'({last_ovf, last_unf}), 0);

        // MUL overflow and underflow.
        applyStimulus(1'b1, 0, 200, 200, 1'b1);
        drain(6);
        checkOutput("mul_ovf_flag", int'(last_ovf), 1);
`ifdef EXPONENT_ALU_SATURATE_EN
        checkOutput("mul_ovf_res", last_res, 255);
`else
        checkOutput("mul_ovf_res", last_res, 273);
`endif
        applyStimulus(1'b1, 0, 10, 20, 1'b1);
        drain(6);
        checkOutput("mul_unf_flag", int'(last_unf), 1);
`ifdef EXPONENT_ALU_SATURATE_EN
        checkOutput("mul_unf_res", last_res, 0);
`else
        checkOutput("mul_unf_res", last_res, -97);
`endif

        // ALIGN both orders, back to back.
        applyStimulus(1'b1, 2, 5, 9, 1'b1);
        drain(6);
        checkOutput("align_res_a", last_res, 4);
        checkOutput("align_swap_a", int'(last_swap), 1);
        applyStimulus(1'b1, 2, 9, 5, 1'b1);
        drain(6);
        checkOutput("align_res_b", last_res, 4);
        checkOutput("align_swap_b", int'(last_swap), 0);

        // Backpressure: three ops offered, out_ready low for five cycles.
        out_count = 0;
        applyStimulus(1'b1, 0, 130, 129, 1'b0);
        applyStimulus(1'b1, 1, 100, 200, 1'b0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 2, 5, 9, 1'b0);
            checkOutput("bp_in_ready_low", int'(in_ready), 0);
        end
        for (int i = 0; i < 4 && !accepted; i++) begin
            applyStimulus(1'b1, 2, 5, 9, 1'b1);
        end
        checkOutput("bp_third_accepted", int'(accepted), 1);
        drain(8);
        checkOutput("bp_out_count", out_count, 3);
        checkOutput("bp_last_res", last_res, 4);

        // Reset with both stages full.
        applyStimulus(1'b1, 0, 200, 200, 1'b0);
        applyStimulus(1'b1, 0, 10, 20, 1'b0);
        @(posedge clk);
        #2;
        in_valid = 1'b0;
        checkOutput("rst_full_out_valid", int'(out_valid), 1);
        checkOutput("rst_full_in_ready", int'(in_ready), 0);
        rst_n = 1'b0;
        #1;
        q.delete();
        checkOutput("rst_mid_out_valid", int'(out_valid), 0);
        checkOutput("rst_mid_res", int'(res), 0);
        checkOutput("rst_mid_ovf", int'(ovf), 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 0, 0, 0, 1'b1);
            checkOutput("post_rst_out_valid", int'(out_valid), 0);
        end

        // Randomised traffic with random backpressure.
        for (int i = 0; i < 300; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                          int'($urandom_range(0, MAXV)), int'($urandom_range(0, MAXV)),
                          ($urandom_range(0, 9) < 7));
        end
        drain(20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
